// File: rtl/muldiv_unit.sv
// Iterative MIPS-style HI/LO multiply/divide unit: one shift-add or restoring
// shift-subtract step per cycle, plus MTHI/MTLO writes and an MFHI/MFLO read mux.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] result
);

  localparam int CNT_W = $clog2(WIDTH);

  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MTLO  = 6'b010011;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FINISH} state_t;

  function automatic logic [WIDTH-1:0] magnitude(input logic signed [WIDTH-1:0] v,
                                                 input logic is_signed);
    logic [WIDTH-1:0] m;
    m = v;
    if (is_signed && v[WIDTH-1]) m = -m;
    return m;
  endfunction

  function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v, input logic n);
    return n ? -v : v;
  endfunction

  function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] v, input logic n);
    return n ? -v : v;
  endfunction

  // Control state (reset)
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  // Datapath state (no reset): work holds {acc, multiplier} or {remainder, quotient}
  logic [2*WIDTH-1:0] work_q, work_d;
  logic [WIDTH-1:0]   opb_q, opb_d;
  logic               is_div_q, is_div_d;
  logic               qneg_q, qneg_d;
  logic               rneg_q, rneg_d;
  logic               dz_q, dz_d;

  logic               is_muldiv, is_div, is_signed;
  logic [WIDTH-1:0]   work_hi, work_lo;
  logic [WIDTH:0]     sum, shifted, diff;
  logic [2*WIDTH-1:0] prod_fix;

  always_comb begin
    is_div    = (funct == F_DIV) || (funct == F_DIVU);
    is_muldiv = is_div || (funct == F_MULT) || (funct == F_MULTU);
    is_signed = (funct == F_MULT) || (funct == F_DIV);

    work_hi  = work_q[2*WIDTH-1:WIDTH];
    work_lo  = work_q[WIDTH-1:0];
    sum      = {1'b0, work_hi} + {1'b0, (work_lo[0] ? opb_q : '0)};
    shifted  = {work_hi, work_lo[WIDTH-1]};
    diff     = shifted - {1'b0, opb_q};
    prod_fix = neg_2w(work_q, qneg_q);

    state_d  = state_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;
    hi_d     = hi_q;
    lo_d     = lo_q;
    work_d   = work_q;
    opb_d    = opb_q;
    is_div_d = is_div_q;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;
    dz_d     = dz_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if (funct == F_MTHI) hi_d = a;
          if (funct == F_MTLO) lo_d = a;
          if (is_muldiv) begin
            state_d  = S_RUN;
            cnt_d    = '0;
            is_div_d = is_div;
            qneg_d   = is_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
            rneg_d   = is_signed && a[WIDTH-1];
            dz_d     = (b == '0);
            opb_d    = is_div ? magnitude(b, is_signed) : magnitude(a, is_signed);
            work_d   = {{WIDTH{1'b0}}, (is_div ? magnitude(a, is_signed) : magnitude(b, is_signed))};
          end
        end
      end
      S_RUN: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(WIDTH - 1)) state_d = S_FINISH;
        if (!is_div_q) begin
          work_d = {sum, work_lo[WIDTH-1:1]};
        end else if (diff[WIDTH]) begin
          work_d = {shifted[WIDTH-1:0], work_lo[WIDTH-2:0], 1'b0};
        end else begin
          work_d = {diff[WIDTH-1:0], work_lo[WIDTH-2:0], 1'b1};
        end
      end
      S_FINISH: begin
        // A zero divisor leaves an all-ones quotient that must not be sign-flipped
        if (is_div_q) begin
          hi_d = neg_w(work_hi, rneg_q);
          lo_d = dz_q ? work_lo : neg_w(work_lo, qneg_q);
        end else begin
          {hi_d, lo_d} = prod_fix;
        end
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  always_ff @(posedge clk) begin
    work_q   <= work_d;
    opb_q    <= opb_d;
    is_div_q <= is_div_d;
    qneg_q   <= qneg_d;
    rneg_q   <= rneg_d;
    dz_q     <= dz_d;
  end

  assign busy   = (state_q != S_IDLE);
  assign done   = done_q;
  assign hi     = hi_q;
  assign lo     = lo_q;
  assign result = (funct == F_MFLO) ? lo_q : hi_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit at WIDTH=32: expected {hi,lo} is queued at
// issue time from a wide-integer reference model and popped when done pulses.
module tb_muldiv_unit;
  localparam int W = 32;

  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MTLO  = 6'b010011;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic [5:0]   funct = '0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy, done;
  logic [W-1:0] hi, lo, result;

  int n_checks = 0;
  int n_fail   = 0;
  logic [2*W-1:0] sb_q[$];

  muldiv_unit #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .funct(funct), .a(a), .b(b),
    .busy(busy), .done(done), .hi(hi), .lo(lo), .result(result)
  );

  always #5 clk = ~clk;

  function automatic logic [2*W-1:0] model(input logic [5:0] f, input logic [W-1:0] x,
                                           input logic [W-1:0] y);
    longint          sx, sy, sq, sr;
    longint unsigned ux, uy, uq, ur;
    logic [63:0]     qv, rv;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = {32'b0, x};
    uy = {32'b0, y};
    case (f)
      F_MULT:  return 64'(sx * sy);
      F_MULTU: return 64'(ux * uy);
      F_DIV: begin
        if (y == '0) return {x, {W{1'b1}}};
        sq = sx / sy; sr = sx % sy;
        qv = sq; rv = sr;
        return {rv[W-1:0], qv[W-1:0]};
      end
      F_DIVU: begin
        if (y == '0) return {x, {W{1'b1}}};
        uq = ux / uy; ur = ux % uy;
        qv = uq; rv = ur;
        return {rv[W-1:0], qv[W-1:0]};
      end
      default: return '0;
    endcase
  endfunction

  // Called at a negedge; holds start for exactly one rising edge.
  task automatic issue(input logic [5:0] f, input logic [W-1:0] x, input logic [W-1:0] y,
                       input bit push);
    start = 1'b1; funct = f; a = x; b = y;
    if (push) sb_q.push_back(model(f, x, y));
    @(negedge clk);
    start = 1'b0;
  endtask

  // Counts edges since the start edge until done is seen at a negedge.
  task automatic wait_done(output int lat, output int busy_cyc, output bit seen);
    lat = 0; busy_cyc = 0; seen = 0;
    while (lat <= 100) begin
      if (done) begin
        seen = 1;
        break;
      end
      if (busy) busy_cyc++;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset();
    #1 reset = 1'b1;
    #2;
    n_checks++;
    if ({busy, done, hi, lo} !== '0) begin
      n_fail++;
      $display("FAIL reset_state: busy=%b done=%b hi=%h lo=%h, required all zero", busy, done, hi, lo);
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    issue(F_MTLO, 32'h5A5A_0F0F, 32'h0, 0);
    n_checks++;
    if (lo !== 32'h5A5A_0F0F || hi !== '0 || busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL first_start_mtlo: lo=%h hi=%h busy=%b done=%b, required lo=5a5a0f0f hi=0 busy=0 done=0",
               lo, hi, busy, done);
    end
  endtask

  task automatic test_moves();
    issue(F_MTHI, 32'h1111_2222, 32'h0, 0);
    funct = F_MFHI; #1;
    n_checks++;
    if (hi !== 32'h1111_2222 || result !== 32'h1111_2222) begin
      n_fail++;
      $display("FAIL mthi_mfhi: hi=%h result=%h, required 11112222", hi, result);
    end
    funct = F_MFLO; #1;
    n_checks++;
    if (result !== 32'h5A5A_0F0F) begin
      n_fail++;
      $display("FAIL mflo_result: result=%h, required 5a5a0f0f", result);
    end
    @(negedge clk);
    issue(6'b111111, 32'hDEAD_BEEF, 32'h3, 0);
    n_checks++;
    if (hi !== 32'h1111_2222 || lo !== 32'h5A5A_0F0F || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL illegal_funct: hi=%h lo=%h busy=%b, required 11112222 5a5a0f0f 0", hi, lo, busy);
    end
  endtask

  task automatic test_mult();
    int lat, bc; bit seen;
    logic [2*W-1:0] exp_v;
    @(negedge clk);
    issue(F_MULT, 32'hFFFF_FFFD, 32'd5, 1);
    wait_done(lat, bc, seen);
    exp_v = sb_q.pop_front();
    n_checks++;
    if (!seen || lat != 33 || bc != 33) begin
      n_fail++;
      $display("FAIL mult_timing: seen=%0d latency=%0d busy_cycles=%0d, required 1 33 33", seen, lat, bc);
    end
    n_checks++;
    if ({hi, lo} !== exp_v || exp_v !== 64'hFFFF_FFFF_FFFF_FFF1) begin
      n_fail++;
      $display("FAIL mult_value: got %h, required %h", {hi, lo}, exp_v);
    end
    @(negedge clk);
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b0 || {hi, lo} !== exp_v) begin
      n_fail++;
      $display("FAIL done_one_cycle: done=%b busy=%b hilo=%h, required 0 0 %h", done, busy, {hi, lo}, exp_v);
    end
  endtask

  task automatic test_div();
    int lat, bc; bit seen;
    logic [2*W-1:0] exp_v;
    logic [5:0] fs[5]     = '{F_DIVU, F_DIV, F_DIV, F_DIV, F_DIV};
    logic [W-1:0] as_[5]  = '{32'd100, 32'hFFFF_FFF9, 32'h1234_5678, 32'h8000_0000, 32'hFFFF_FFF0};
    logic [W-1:0] bs_[5]  = '{32'd7, 32'd2, 32'h0, 32'hFFFF_FFFF, 32'h0};
    logic [2*W-1:0] k_[5] = '{{32'd2, 32'd14}, {32'hFFFF_FFFF, 32'hFFFF_FFFD},
                              {32'h1234_5678, 32'hFFFF_FFFF}, {32'h0, 32'h8000_0000},
                              {32'hFFFF_FFF0, 32'hFFFF_FFFF}};
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      issue(fs[i], as_[i], bs_[i], 1);
      wait_done(lat, bc, seen);
      exp_v = (sb_q.size() > 0) ? sb_q.pop_front() : '0;
      n_checks++;
      if (!seen || lat != 33) begin
        n_fail++;
        $display("FAIL div_timing_%0d: seen=%0d latency=%0d, required 1 33", i, seen, lat);
      end
      n_checks++;
      if ({hi, lo} !== exp_v || exp_v !== k_[i]) begin
        n_fail++;
        $display("FAIL div_value_%0d: got hi=%h lo=%h, required %h", i, hi, lo, k_[i]);
      end
    end
  endtask

  task automatic test_ignore_start();
    int lat, bc, extra; bit seen;
    logic [2*W-1:0] exp_v;
    @(negedge clk);
    issue(F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1);
    repeat (5) @(negedge clk);
    issue(F_MTHI, 32'h0BAD_0BAD, 32'd3, 0);
    issue(F_MULT, 32'd2, 32'd3, 0);
    n_checks++;
    if (hi === 32'h0BAD_0BAD) begin
      n_fail++;
      $display("FAIL mthi_during_run: hi=%h, required unchanged", hi);
    end
    wait_done(lat, bc, seen);
    exp_v = sb_q.pop_front();
    n_checks++;
    if (!seen || lat != 26 || {hi, lo} !== exp_v || exp_v !== 64'hFFFF_FFFE_0000_0001) begin
      n_fail++;
      $display("FAIL multu_ignore: seen=%0d edges_left=%0d hilo=%h, required 1 26 %h", seen, lat, {hi, lo}, exp_v);
    end
    extra = 0;
    repeat (40) begin
      @(negedge clk);
      if (done || busy) extra++;
    end
    n_checks++;
    if (extra != 0) begin
      n_fail++;
      $display("FAIL second_start_ignored: activity_cycles=%0d, required 0", extra);
    end
  endtask

  task automatic test_back_to_back();
    int lat, bc; bit seen;
    logic [2*W-1:0] exp_v;
    @(negedge clk);
    issue(F_MULT, 32'h8000_0000, 32'h8000_0000, 1);
    wait_done(lat, bc, seen);
    exp_v = sb_q.pop_front();
    n_checks++;
    if (!seen || {hi, lo} !== exp_v) begin
      n_fail++;
      $display("FAIL b2b_first: seen=%0d hilo=%h, required %h", seen, {hi, lo}, exp_v);
    end
    issue(F_MULTU, 32'd2, 32'd3, 1);
    wait_done(lat, bc, seen);
    exp_v = sb_q.pop_front();
    n_checks++;
    if (!seen || lat != 33 || bc != 33 || {hi, lo} !== exp_v || exp_v !== 64'd6) begin
      n_fail++;
      $display("FAIL b2b_second: seen=%0d latency=%0d busy=%0d hilo=%h, required 1 33 33 %h",
               seen, lat, bc, {hi, lo}, exp_v);
    end
  endtask

  task automatic test_random();
    int lat, bc; bit seen;
    logic [2*W-1:0] exp_v;
    logic [5:0] ops[4] = '{F_MULT, F_MULTU, F_DIV, F_DIVU};
    logic [W-1:0] x, y;
    for (int i = 0; i < 10; i++) begin
      x = $urandom;
      y = (i % 3 == 0) ? W'($urandom_range(0, 15)) : $urandom;
      if (i % 2 == 1) y = {{16{y[15]}}, y[15:0]};
      @(negedge clk);
      issue(ops[i % 4], x, y, 1);
      wait_done(lat, bc, seen);
      exp_v = (sb_q.size() > 0) ? sb_q.pop_front() : '0;
      n_checks++;
      if (!seen || lat != 33 || {hi, lo} !== exp_v) begin
        n_fail++;
        $display("FAIL random_%0d: op=%b a=%h b=%h latency=%0d hilo=%h, required %h",
                 i, ops[i % 4], x, y, lat, {hi, lo}, exp_v);
      end
    end
  endtask

  task automatic test_reset_abort();
    int dcount;
    @(negedge clk);
    issue(F_DIV, 32'd1000, 32'd3, 0);
    repeat (9) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if ({busy, done, hi, lo} !== '0) begin
      n_fail++;
      $display("FAIL reset_abort_state: busy=%b done=%b hi=%h lo=%h, required all zero", busy, done, hi, lo);
    end
    @(negedge clk);
    reset = 1'b0;
    dcount = 0;
    repeat (40) begin
      @(negedge clk);
      if (done || busy || hi !== '0 || lo !== '0) dcount++;
    end
    n_checks++;
    if (dcount != 0) begin
      n_fail++;
      $display("FAIL reset_abort_quiet: active_cycles=%0d, required 0", dcount);
    end
    issue(F_MTHI, 32'hCAFE_F00D, 32'h0, 0);
    funct = F_MFHI; #1;
    n_checks++;
    if (hi !== 32'hCAFE_F00D || result !== 32'hCAFE_F00D || done !== 1'b0) begin
      n_fail++;
      $display("FAIL mthi_after_reset: hi=%h result=%h done=%b, required cafef00d cafef00d 0", hi, result, done);
    end
  endtask

  initial begin
    test_reset();
    test_moves();
    test_mult();
    test_div();
    test_ignore_start();
    test_back_to_back();
    test_random();
    test_reset_abort();
    n_checks++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", sb_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand and HI/LO width; legal range 4..64.
REQ-002 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port start  input  1  request strobe, qualifies funct/a/b for one cycle.
REQ-005 SHALL have port funct  input  6  MIPS R-type function field selecting the operation.
REQ-006 SHALL have port a  input  WIDTH  rs operand: multiplicand, dividend, or MTHI/MTLO data.
REQ-007 SHALL have port b  input  WIDTH  rt operand: multiplier or divisor.
REQ-008 SHALL have port busy  output  1  high while a multiply/divide is in progress.
REQ-009 SHALL have port done  output  1  one-cycle pulse when HI/LO take a mult/div result.
REQ-010 SHALL have port hi  output  WIDTH  HI register.
REQ-011 SHALL have port lo  output  WIDTH  LO register.
REQ-012 SHALL have port result  output  WIDTH  combinational read: lo when funct=010010 (MFLO), else hi.

Function
REQ-013 SHALL decode funct: 011000 MULT, 011001 MULTU, 011010 DIV, 011011 DIVU, 010001 MTHI, 010011 MTLO; other codes with start SHALL be ignored.
REQ-014 SHALL implement states IDLE, RUN, FINISH; busy = (state != IDLE).
REQ-015 SHALL accept start only in IDLE; start in RUN or FINISH is ignored with no side effect.
REQ-016 MTHI/MTLO with start in IDLE SHALL write a into hi/lo at that edge; state stays IDLE; no done.
REQ-017 Mult/div start in IDLE SHALL latch operand magnitudes (signed ops: absolute values; unsigned: raw), record result signs, clear the iteration counter, and enter RUN.
REQ-018 RUN SHALL perform one iteration per cycle for exactly WIDTH cycles: shift-add for multiply, restoring shift-subtract for divide; then enter FINISH.
REQ-019 FINISH SHALL apply sign correction, write hi/lo, set done for exactly one cycle, and return to IDLE on the same edge.
REQ-020 Latency: hi/lo update and done rising SHALL occur WIDTH+1 edges after the start edge; busy high for exactly WIDTH+1 cycles.
REQ-021 Multiply: {hi,lo} = 2*WIDTH-bit full product; MULT two's-complement, MULTU unsigned.
REQ-022 Divide: lo = quotient truncated toward zero, hi = remainder with sign of dividend (DIV); unsigned for DIVU.
REQ-023 Divisor zero: SHALL complete normally with lo = all ones, hi = a; no hang, no error flag.
REQ-024 DIV of most-negative by -1: lo = most-negative (wraps), hi = 0.
REQ-025 start in the done cycle (state IDLE) SHALL be accepted, giving back-to-back operations.
REQ-026 hi/lo SHALL hold value at all times other than REQ-016 and REQ-019 writes.

Reset
REQ-027 reset high SHALL immediately force state IDLE, busy 0, done 0, hi 0, lo 0, counter 0, independent of clk.
REQ-028 reset mid-RUN SHALL abort the operation; no done pulse and no hi/lo write after release.
REQ-029 First start SHALL be accepted on the first rising edge with reset low.

Verification (WIDTH=32)
REQ-030 MULT a=FFFFFFFD (-3), b=5 -> done 33 edges after start; hi=FFFFFFFF, lo=FFFFFFF1; busy high 33 cycles.
REQ-031 DIVU a=100, b=7 -> lo=14, hi=2; DIV a=FFFFFFF9 (-7), b=2 -> lo=FFFFFFFD, hi=FFFFFFFF.
REQ-032 DIV a=12345678, b=0 -> lo=FFFFFFFF, hi=12345678, done pulse after 33 edges.
REQ-033 MULTU a=FFFFFFFF, b=FFFFFFFF, start re-pulsed mid-RUN with other operands -> hi=FFFFFFFE, lo=00000001, second start ignored.
REQ-034 Reset asserted 10 cycles into a DIV -> busy/done/hi/lo 0 immediately, no done after release; then MTHI a=CAFEF00D -> hi=CAFEF00D next edge, result=CAFEF00D with funct=010000.
REQ-035 Start MULTU 2*3 in done cycle of prior MULT -> accepted; lo=6, hi=0 after a further 33 edges.
